// File: rtl/frame_writer.sv
// Camera-to-frame-buffer writer: crops a marker-framed pixel stream into a
// FB_WIDTH x FB_HEIGHT buffer (addr = x + FB_WIDTH*y) with continuous or
// snapshot capture. Define FRAME_WRITER_DECIMATE_EN for 2:1 decimation on both axes.
module frame_writer #(
  parameter int FB_WIDTH  = 240,
  parameter int FB_HEIGHT = 320,
  parameter int ADDR_W    = 17,
  parameter int PIX_W     = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              pixel_valid_in,
  input  logic [PIX_W-1:0]  pixel_data_in,
  input  logic              frame_start_in,
  input  logic              line_start_in,
  input  logic              snapshot_mode_in,
  input  logic              snapshot_in,
  output logic              we_out,
  output logic [ADDR_W-1:0] waddr_out,
  output logic [PIX_W-1:0]  wdata_out,
  output logic              frame_done_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

  localparam logic [10:0]       FBW_X    = 11'(FB_WIDTH);
  localparam logic [9:0]        FBH_Y    = 10'(FB_HEIGHT);
  localparam logic [10:0]       LAST_X   = 11'(FB_WIDTH - 1);
  localparam logic [9:0]        LAST_Y   = 10'(FB_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

  state_t            state, state_nx;
  logic [10:0]       x, x_nx, dx;
  logic [9:0]        y, y_nx, dy;
  logic [ADDR_W-1:0] row_base, rb_nx, addr;
  logic              fs, ls, phase_ok, in_win, wr, done;

  assign fs = pixel_valid_in & frame_start_in;
  assign ls = pixel_valid_in & line_start_in & ~frame_start_in;

  // Position of the pixel being presented this cycle; counters saturate.
  always_comb begin
    x_nx  = x;
    y_nx  = y;
    rb_nx = row_base;
    if (fs) begin
      x_nx  = '0;
      y_nx  = '0;
      rb_nx = '0;
    end else if (ls) begin
      x_nx = '0;
      y_nx = (y == '1) ? y : y + 10'd1;
`ifdef FRAME_WRITER_DECIMATE_EN
      if (!y_nx[0]) rb_nx = row_base + ROW_STEP;
`else
      rb_nx = row_base + ROW_STEP;
`endif
    end else if (pixel_valid_in) begin
      x_nx = (x == '1) ? x : x + 11'd1;
    end
  end

`ifdef FRAME_WRITER_DECIMATE_EN
  assign dx       = x_nx >> 1;
  assign dy       = y_nx >> 1;
  assign phase_ok = ~x_nx[0] & ~y_nx[0];
`else
  assign dx       = x_nx;
  assign dy       = y_nx;
  assign phase_ok = 1'b1;
`endif

  assign in_win = (dx < FBW_X) && (dy < FBH_Y);
  // The frame_start pixel seen in ARMED is the first write of the frame.
  assign wr     = pixel_valid_in && phase_ok && in_win &&
                  ((state == CAPTURE) || ((state == ARMED) && fs));
  assign done   = wr && (dx == LAST_X) && (dy == LAST_Y);
  assign addr   = rb_nx + ADDR_W'(dx);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!snapshot_mode_in || snapshot_in) state_nx = ARMED;
      ARMED:   if (fs) state_nx = CAPTURE;
      CAPTURE: state_nx = CAPTURE;
      HOLD:    if (snapshot_in || !snapshot_mode_in) state_nx = ARMED;
      default: state_nx = IDLE;
    endcase
    if (done) state_nx = snapshot_mode_in ? HOLD : ARMED;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      row_base       <= '0;
      we_out         <= 1'b0;
      waddr_out      <= '0;
      wdata_out      <= '0;
      frame_done_out <= 1'b0;
    end else begin
      state          <= state_nx;
      x              <= x_nx;
      y              <= y_nx;
      row_base       <= rb_nx;
      we_out         <= wr;
      frame_done_out <= done;
      if (wr) begin
        waddr_out <= addr;
        wdata_out <= pixel_data_in;
      end
    end
  end

  assign busy_out = (state == CAPTURE);

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer on a small 8x6 buffer: crop, gapped stream,
// resync, mid-frame reset and snapshot/hold sequencing.
module tb_frame_writer;
  localparam int FBW = 8, FBH = 6, AW = 17, PW = 16;
`ifdef FRAME_WRITER_DECIMATE_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam int SW = SC*FBW + 2*SC, SH = SC*FBH + 2*SC;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          valid = 1'b0, fs = 1'b0, ls = 1'b0, mode = 1'b0, snap = 1'b0;
  logic [PW-1:0] data = '0;
  logic          we, done, busy;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wdata;

  frame_writer #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pixel_valid_in(valid), .pixel_data_in(data),
    .frame_start_in(fs), .line_start_in(ls), .snapshot_mode_in(mode),
    .snapshot_in(snap), .we_out(we), .waddr_out(waddr), .wdata_out(wdata),
    .frame_done_out(done), .busy_out(busy)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Source pixel -> expected buffer write, straight from the geometry.
  function automatic void map(input int x, input int y, output bit wr, output int a);
`ifdef FRAME_WRITER_DECIMATE_EN
    wr = (x % 2 == 0) && (y % 2 == 0) && (x/2 < FBW) && (y/2 < FBH);
    a  = (y/2)*FBW + x/2;
`else
    wr = (x < FBW) && (y < FBH);
    a  = y*FBW + x;
`endif
  endfunction

  task automatic step(input string tag, input bit ew, input int ea, input logic [PW-1:0] ed,
                      input bit edone, input bit ebusy);
    @(posedge clk); #1;
    chk({tag, " we"}, we, ew);
    if (ew) begin
      chk({tag, " addr"}, waddr, ea);
      chk({tag, " data"}, wdata, ed);
    end
    chk({tag, " done"}, done, edone);
    chk({tag, " busy"}, busy, ebusy);
  endtask

  // cap: frame expected to be written; stops before (cut_x,cut_y) if reached.
  task automatic frame(input bit cap, input bit gaps, input logic [PW-1:0] salt,
                       input int cut_x, input int cut_y, input bit with_fs);
    bit wr, dn, seen;
    int a;
    seen = 1'b0;
    for (int y = 0; y < SH; y++) begin
      for (int x = 0; x < SW; x++) begin
        if (x == cut_x && y == cut_y) begin
          valid = 1'b0; fs = 1'b0; ls = 1'b0;
          return;
        end
        @(negedge clk);
        valid = 1'b1;
        fs    = with_fs && x == 0 && y == 0;
        ls    = x == 0 && y > 0;
        data  = salt ^ {y[7:0], x[7:0]};
        map(x, y, wr, a);
        wr = wr && cap && !seen;
        dn = wr && (a == FBW*FBH - 1);
        if (dn) seen = 1'b1;
        step($sformatf("px(%0d,%0d)", x, y), wr, a, data, dn, cap && !seen);
        if (gaps) begin
          @(negedge clk);
          valid = 1'b0; fs = 1'b0; ls = 1'b0;
          step($sformatf("gap(%0d,%0d)", x, y), 1'b0, 0, '0, 1'b0, cap && !seen);
        end
      end
    end
    @(negedge clk);
    valid = 1'b0; fs = 1'b0; ls = 1'b0;
  endtask

  task automatic pulse_snap();
    @(negedge clk) snap = 1'b1;
    @(negedge clk) snap = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst we", we, 0);
    chk("rst addr", waddr, 0);
    chk("rst data", wdata, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // Continuous capture: full rate, then a gapped stream.
    frame(1, 0, 16'h1000, -1, -1, 1);
    frame(1, 1, 16'h2000, -1, -1, 1);

    // Resync: frame_start mid-capture restarts at address 0, no early done.
    frame(1, 0, 16'h3000, 5, 3, 1);
    frame(1, 0, 16'h4000, -1, -1, 1);

    // Mid-frame reset: outputs clear asynchronously; partial frame is abandoned.
    frame(1, 0, 16'h5000, 3, 2, 1);
    chk("pre-rst we", we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async we", we, 0);
    chk("async addr", waddr, 0);
    chk("async busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    frame(0, 0, 16'h6000, -1, -1, 0);
    frame(1, 0, 16'h7000, -1, -1, 1);

    // Snapshot: idle until armed, one frame, then held.
    mode = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    frame(0, 0, 16'h8000, -1, -1, 1);
    pulse_snap();
    frame(1, 0, 16'h9000, -1, -1, 1);
    frame(0, 0, 16'ha000, -1, -1, 1);
    frame(0, 1, 16'hb000, -1, -1, 1);
    chk("hold busy", busy, 0);
    pulse_snap();
    frame(1, 0, 16'hc000, -1, -1, 1);
    frame(0, 0, 16'hd000, -1, -1, 1);
    // Leaving snapshot mode from HOLD resumes continuous capture.
    @(negedge clk) mode = 1'b0;
    @(negedge clk);
    frame(1, 0, 16'he000, -1, -1, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
